// File: rtl/event_monitor_pkg.sv
// Shared types for the event monitor: capture FSM states and small arithmetic helpers.
package event_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_t;

  function automatic logic [31:0] clamp_u32(input logic [31:0] value, input logic [31:0] limit);
    if (value > limit) begin
      return limit;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/trace_capture_checker.sv
// Invariants on the capture controller outputs.
module trace_capture_checker
  import event_monitor_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  input cap_state_t state,
  input logic       arm,
  input logic       done,
  input logic       rd_valid
);

  a_arm_in_armed: assert property (@(posedge clk) disable iff (!rst_n) arm |-> (state == ARMED));
  a_arm_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(arm && done));
  a_rd_valid_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(rd_valid));

endmodule

// File: rtl/trace_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port, contents not reset.
module trace_ram #(
  parameter int W      = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_r [DEPTH];
  logic [W-1:0] rdata_r;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/trace_capture.sv
// Trigger-centred trace capture: circular sample buffer, post-trigger countdown, read-back in DONE.
module trace_capture
  import event_monitor_pkg::*;
#(
  parameter int PROBE_W = 32,
  parameter int DEPTH   = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic               abort,
  input  logic [PROBE_W-1:0] probe_data,
  input  logic               trigger_hit,
  input  logic [ADDR_W-1:0]  post_count,
  output logic               arm,
  output logic               done,
  output logic [ADDR_W-1:0]  trig_addr,
  output logic               wrapped,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  cap_state_t          state_r, state_nxt_s;
  logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_W-1:0]   remaining_r, remaining_nxt_s;
  logic [ADDR_W-1:0]   trig_addr_r, trig_addr_nxt_s;
  logic [ADDR_W-1:0]   post_clamp_s;
  logic                wrapped_r, wrapped_nxt_s;
  logic                arm_r, done_r, rd_valid_r;
  logic                we_s, re_s;
  logic [PROBE_W-1:0]  ram_q_s;

  // Clamped so the trigger sample can never be overwritten by its own post-trigger window
  assign post_clamp_s = ADDR_W'(clamp_u32(32'(post_count), 32'(LAST_ADDR)));

  // next-state, write-enable and pointer bookkeeping
  always_comb begin
    state_nxt_s     = state_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    remaining_nxt_s = remaining_r;
    trig_addr_nxt_s = trig_addr_r;
    wrapped_nxt_s   = wrapped_r;
    we_s            = 1'b0;
    if (abort) begin
      state_nxt_s = IDLE;
    end else if (start) begin
      state_nxt_s     = ARMED;
      wr_ptr_nxt_s    = '0;
      remaining_nxt_s = '0;
      wrapped_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        ARMED: begin
          if (en) begin
            we_s = 1'b1;
            if (trigger_hit) begin
              trig_addr_nxt_s = wr_ptr_r;
              remaining_nxt_s = post_clamp_s;
              state_nxt_s     = (post_clamp_s == '0) ? DONE : POST;
            end else begin
              state_nxt_s = ARMED;
            end
          end else begin
            state_nxt_s = ARMED;
          end
        end
        POST: begin
          if (en) begin
            we_s            = 1'b1;
            remaining_nxt_s = remaining_r - ADDR_W'(1);
            state_nxt_s     = (remaining_r == ADDR_W'(1)) ? DONE : POST;
          end else begin
            state_nxt_s = POST;
          end
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
      if (we_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
        if (wr_ptr_r == LAST_ADDR) begin
          wrapped_nxt_s = 1'b1;
        end else begin
          wrapped_nxt_s = wrapped_r;
        end
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
    end
  end

  assign re_s = rd_en && (state_r == DONE);

  // state, pointers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wr_ptr_r    <= '0;
      remaining_r <= '0;
      trig_addr_r <= '0;
      wrapped_r   <= 1'b0;
      arm_r       <= 1'b0;
      done_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      remaining_r <= remaining_nxt_s;
      trig_addr_r <= trig_addr_nxt_s;
      wrapped_r   <= wrapped_nxt_s;
      arm_r       <= (state_nxt_s == ARMED);
      done_r      <= (state_nxt_s == DONE);
      rd_valid_r  <= re_s;
    end
  end

  trace_ram #(
    .W      (PROBE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (probe_data),
    .re    (re_s),
    .raddr (rd_addr),
    .rdata (ram_q_s)
  );

  trace_capture_checker u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_r),
    .arm      (arm_r),
    .done     (done_r),
    .rd_valid (rd_valid_r)
  );

  assign arm       = arm_r;
  assign done      = done_r;
  assign trig_addr = trig_addr_r;
  assign wrapped   = wrapped_r;
  assign rd_valid  = rd_valid_r;
  // RAM output has no reset, so mask it to keep rd_data at zero out of reset
  assign rd_data   = rd_valid_r ? ram_q_s : '0;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture at DEPTH=8: capture scenarios, read-back and control priorities.
module tb_trace_capture;

  localparam int PW = 16;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n, en, start, abort, trigger_hit, rd_en;
  logic [PW-1:0] probe_data;
  logic [AW-1:0] post_count, rd_addr;
  logic          arm, done, wrapped, rd_valid;
  logic [AW-1:0] trig_addr;
  logic [PW-1:0] rd_data;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [PW-1:0] mdl [DP];
  logic [AW-1:0] mptr;
  logic [PW-1:0] exp_q [$];

  trace_capture #(.PROBE_W(PW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort),
    .probe_data(probe_data), .trigger_hit(trigger_hit), .post_count(post_count),
    .arm(arm), .done(done), .trig_addr(trig_addr), .wrapped(wrapped),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    mptr  = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [PW-1:0] d, input logic hit, input logic wr);
    en          = 1'b1;
    probe_data  = d;
    trigger_hit = hit;
    if (wr) begin
      mdl[mptr] = d;
      mptr      = mptr + 3'd1;
    end
    tick();
    en          = 1'b0;
    trigger_hit = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [PW-1:0] e;
    exp_q.push_back(mdl[a]);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq("rd_valid", 32'(rd_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_valid) check_eq("rd_data", 32'(rd_data), 32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; abort = 1'b0; trigger_hit = 1'b0;
    rd_en = 1'b0; rd_addr = '0; probe_data = '0; post_count = '0; mptr = '0;
    repeat (2) tick();
    check_eq("rst_arm", 32'(arm), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wrapped", 32'(wrapped), 32'd0);
    check_eq("rst_trig", 32'(trig_addr), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // hit on 5th sample, three post samples; last write wraps the pointer
    do_start();
    check_eq("s1_arm", 32'(arm), 32'd1);
    check_eq("s1_done0", 32'(done), 32'd0);
    post_count = 3'd3;
    for (int i = 0; i < 4; i++) sample(16'hA100 + 16'(i), 1'b0, 1'b1);
    sample(16'hA104, 1'b1, 1'b1);
    check_eq("s1_arm_post", 32'(arm), 32'd0);
    check_eq("s1_trig", 32'(trig_addr), 32'd4);
    sample(16'hA105, 1'b1, 1'b1);
    check_eq("s1_trig_hold", 32'(trig_addr), 32'd4);
    sample(16'hA106, 1'b0, 1'b1);
    check_eq("s1_done_early", 32'(done), 32'd0);
    sample(16'hA107, 1'b0, 1'b1);
    check_eq("s1_done", 32'(done), 32'd1);
    check_eq("s1_arm_done", 32'(arm), 32'd0);
    check_eq("s1_wrapped", 32'(wrapped), 32'd1);
    do_read(3'd4);
    do_read(3'd7);
    do_read(3'd0);

    // post_count = 0: DONE right after the hit; DONE must not write
    do_start();
    check_eq("s2_wrapped_clr", 32'(wrapped), 32'd0);
    check_eq("s2_done_clr", 32'(done), 32'd0);
    post_count = 3'd0;
    sample(16'hB000, 1'b0, 1'b1);
    sample(16'hB001, 1'b0, 1'b1);
    sample(16'hB002, 1'b1, 1'b1);
    check_eq("s2_done", 32'(done), 32'd1);
    check_eq("s2_arm", 32'(arm), 32'd0);
    check_eq("s2_trig", 32'(trig_addr), 32'd2);
    sample(16'hBEEF, 1'b0, 1'b0);
    sample(16'hBEEF, 1'b1, 1'b0);
    do_read(3'd2);
    do_read(3'd3);
    tick();
    check_eq("s2_rd_idle", 32'(rd_valid), 32'd0);

    // en low for four cycles in POST delays completion and writes nothing
    do_start();
    post_count = 3'd2;
    sample(16'hC000, 1'b1, 1'b1);
    check_eq("s3_trig", 32'(trig_addr), 32'd0);
    sample(16'hC001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      probe_data  = 16'hDEAD;
      trigger_hit = 1'b1;
      tick();
      check_eq("s3_hold_done", 32'(done), 32'd0);
    end
    trigger_hit = 1'b0;
    sample(16'hC002, 1'b0, 1'b1);
    check_eq("s3_done", 32'(done), 32'd1);
    do_read(3'd2);
    do_read(3'd3);

    // ten samples then the hit: trigger lands at address 2 after a wrap
    do_start();
    post_count = 3'd1;
    for (int i = 0; i < 7; i++) sample(16'hD000 + 16'(i), 1'b0, 1'b1);
    check_eq("s4_not_wrapped", 32'(wrapped), 32'd0);
    for (int i = 7; i < 10; i++) sample(16'hD000 + 16'(i), 1'b0, 1'b1);
    check_eq("s4_wrapped", 32'(wrapped), 32'd1);
    sample(16'hD00A, 1'b1, 1'b1);
    check_eq("s4_trig", 32'(trig_addr), 32'd2);
    sample(16'hD00B, 1'b0, 1'b1);
    check_eq("s4_done", 32'(done), 32'd1);
    do_read(3'd2);
    do_read(3'd7);
    do_read(3'd3);

    // start and abort together in POST: abort wins
    do_start();
    post_count = 3'd3;
    sample(16'hE000, 1'b1, 1'b1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("s5_arm", 32'(arm), 32'd0);
    check_eq("s5_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) sample(16'hFFFF, 1'b1, 1'b0);
    check_eq("s5_idle_done", 32'(done), 32'd0);
    rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    rd_en = 1'b0;
    check_eq("s5_rd_blocked", 32'(rd_valid), 32'd0);

    // restart in POST clears the write pointer
    do_start();
    sample(16'hE010, 1'b1, 1'b1);
    do_start();
    check_eq("s6_rearm", 32'(arm), 32'd1);
    post_count = 3'd0;
    sample(16'hE100, 1'b1, 1'b1);
    check_eq("s6_trig", 32'(trig_addr), 32'd0);
    check_eq("s6_done", 32'(done), 32'd1);
    do_read(3'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("s6_abort_done", 32'(done), 32'd0);

    // reset mid-capture
    do_start();
    post_count = 3'd3;
    sample(16'h1234, 1'b1, 1'b1);
    sample(16'h1235, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("s7_rst_trig", 32'(trig_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("s7_rst_arm", 32'(arm), 32'd0);
    check_eq("s7_rst_done", 32'(done), 32'd0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
